// File: rtl/ann_sram_pkg.sv
// Shared types and defaults for the ANN result SRAM write-back block.
package ann_sram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCollectLo,
    StCollectHi,
    StWrite,
    StDone
  } state_e;

  localparam int unsigned DefAddrW      = 16;
  localparam int unsigned DefWaitCycles = 3;
  localparam int unsigned AddrInc       = 4;

endpackage

// File: rtl/sram_write_timer.sv
// Write-strobe hold timer: counts while start is high, expired flags the final held cycle.
module sram_write_timer
  import ann_sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic expired
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = start && (cnt_q == CntMax);

  // Counter self-clears on expiry or whenever start drops.
  always_comb begin
    cnt_d = '0;
    if (start && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_write.sv
// Packs ANN result halfwords into 32-bit words and writes them to SRAM at consecutive addresses.
// Optional words_written counter is enabled by defining SRAM_WRITE_CNT_EN.
module sram_write
  import ann_sram_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_write,
  input  logic [ADDR_W-1:0] start_address,
  input  logic [15:0]       data_in,
  input  logic              data_valid,
  input  logic              data_last,
  output logic              data_ready,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       write_data,
  output logic              write,
  output logic              busy,
  output logic              done
`ifdef SRAM_WRITE_CNT_EN
  ,
  output logic [ADDR_W-1:0] words_written
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              timer_expired;

  sram_write_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (state_q == StWrite),
    .expired(timer_expired)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (start_write) begin
          addr_d  = start_address;
          wdata_d = '0;
          last_d  = 1'b0;
          state_d = StCollectLo;
        end
      end
      StCollectLo: begin
        if (data_valid) begin
          wdata_d = {16'h0000, data_in};
          if (data_last) begin
            last_d  = 1'b1;
            state_d = StWrite;
          end else begin
            state_d = StCollectHi;
          end
        end
      end
      StCollectHi: begin
        if (data_valid) begin
          wdata_d[31:16] = data_in;
          last_d         = data_last;
          state_d        = StWrite;
        end
      end
      StWrite: begin
        if (timer_expired) begin
          if (last_q) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_q + ADDR_W'(AddrInc);
            state_d = StCollectLo;
          end
        end
      end
      StDone: begin
        last_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  // All strobes decode from the state register, so reset clears them immediately.
  assign data_ready = (state_q == StCollectLo) || (state_q == StCollectHi);
  assign write      = (state_q == StWrite);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign address    = addr_q;
  assign write_data = wdata_q;

`ifdef SRAM_WRITE_CNT_EN
  logic [ADDR_W-1:0] words_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q <= '0;
    end else if ((state_q == StIdle) && start_write) begin
      words_q <= '0;
    end else if ((state_q == StWrite) && timer_expired) begin
      words_q <= words_q + 1'b1;
    end
  end

  assign words_written = words_q;
`endif

endmodule

// File: tb/tb_sram_write.sv
// Self-checking bench for sram_write: directed scenarios plus randomized sessions vs a word-level model.
module tb_sram_write;

  localparam int unsigned AW   = 16;
  localparam int unsigned WAIT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_write;
  logic [AW-1:0] start_address;
  logic [15:0]   data_in;
  logic          data_valid;
  logic          data_last;
  logic          data_ready;
  logic [AW-1:0] address;
  logic [31:0]   write_data;
  logic          write;
  logic          busy;
  logic          done;
`ifdef SRAM_WRITE_CNT_EN
  logic [AW-1:0] words_written;
`endif

  sram_write #(
    .ADDR_W     (AW),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_write  (start_write),
    .start_address(start_address),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_last    (data_last),
    .data_ready   (data_ready),
    .address      (address),
    .write_data   (write_data),
    .write        (write),
    .busy         (busy),
    .done         (done)
`ifdef SRAM_WRITE_CNT_EN
    ,
    .words_written(words_written)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            len;
  } wr_t;

  wr_t         wr_q[$];
  wr_t         cur;
  int          run_len = 0;
  int          unstable = 0;
  int          ready_in_write = 0;
  int          done_cnt = 0;
  logic [15:0] hw_q[$];

  // Observe SRAM-side writes as (address, data, strobe length) records.
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else begin
      if (write === 1'b1) begin
        if (run_len == 0) begin
          cur.addr = address;
          cur.data = write_data;
        end else if (address !== cur.addr || write_data !== cur.data) begin
          unstable++;
        end
        if (data_ready !== 1'b0) ready_in_write++;
        run_len++;
      end else if (run_len > 0) begin
        cur.len = run_len;
        wr_q.push_back(cur);
        run_len = 0;
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic feed(input bit noise, output bit ok);
    int idx = 0;
    int budget = 0;
    bit accepted;
    ok = 1'b1;
    while (idx < hw_q.size()) begin
      @(negedge clk);
      if (budget++ > 2000) begin
        ok = 1'b0;
        break;
      end
      // Odd index means the low half was taken, so the DUT sits in its high-half phase.
      start_write   = noise && (idx % 2 == 1) && ($urandom_range(0, 1) == 1);
      start_address = AW'($urandom);
      if (noise && $urandom_range(0, 3) == 0) begin
        data_valid = 1'b0;
        data_in    = 16'($urandom);
        data_last  = 1'($urandom_range(0, 1));
      end else begin
        data_valid = 1'b1;
        data_in    = hw_q[idx];
        data_last  = (idx == hw_q.size() - 1);
      end
      accepted = data_valid && (data_ready === 1'b1);
      @(posedge clk);
      if (accepted) idx++;
    end
    @(negedge clk);
    data_valid  = 1'b0;
    data_last   = 1'b0;
    start_write = 1'b0;
    data_in     = '0;
  endtask

  task automatic test_session(input string name, input logic [AW-1:0] sa, input bit noise);
    int            n;
    int            nw;
    int            d0;
    int            waited;
    bit            ok;
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    logic [15:0]   hi;
    n  = hw_q.size();
    nw = (n + 1) / 2;
    wr_q.delete();
    unstable       = 0;
    ready_in_write = 0;
    d0             = done_cnt;

    @(negedge clk);
    start_write   = 1'b1;
    start_address = sa;
    @(negedge clk);
    start_write   = 1'b0;
    start_address = AW'($urandom);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    end

    feed(noise, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s feed_timeout: data_ready never accepted all %0d halfwords", name, n);
    end

    #1;
    waited = 0;
    while (done !== 1'b1 && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL %s done_timeout: done=%b expected 1 within 200 cycles", name, done);
    end
    ea = sa + AW'(4 * (nw - 1));
    n_vec++;
    if (address !== ea) begin
      n_err++;
      $display("FAIL %s final_address: got %h expected %h", name, address, ea);
    end
`ifdef SRAM_WRITE_CNT_EN
    n_vec++;
    if (words_written !== AW'(nw)) begin
      n_err++;
      $display("FAIL %s words_written: got %0d expected %0d", name, words_written, nw);
    end
`endif

    @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_after_done: got busy=%b done=%b expected 0 0", name, busy, done);
    end
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - d0);
    end

    n_vec++;
    if (wr_q.size() != nw) begin
      n_err++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wr_q.size(), nw);
    end
    for (int k = 0; k < nw && k < wr_q.size(); k++) begin
      ea = sa + AW'(4 * k);
      hi = (2 * k + 1 < n) ? hw_q[2*k+1] : 16'h0000;
      ed = {hi, hw_q[2*k]};
      n_vec++;
      if (wr_q[k].addr !== ea || wr_q[k].data !== ed || wr_q[k].len != WAIT) begin
        n_err++;
        $display("FAIL %s write[%0d]: got @%h %h x%0d expected @%h %h x%0d", name, k,
                 wr_q[k].addr, wr_q[k].data, wr_q[k].len, ea, ed, WAIT);
      end
    end
    n_vec++;
    if (unstable != 0 || ready_in_write != 0) begin
      n_err++;
      $display("FAIL %s write_phase: got unstable=%0d ready_in_write=%0d expected 0 0",
               name, unstable, ready_in_write);
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if (address !== '0 || write_data !== '0) begin
      n_err++;
      $display("FAIL reset_regs: got addr=%h data=%h expected 0 0", address, write_data);
    end
    n_vec++;
    if (write !== 1'b0 || data_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got w=%b rdy=%b busy=%b done=%b expected 0000",
               write, data_ready, busy, done);
    end
  endtask

  task automatic test_directed();
    hw_q = '{16'h1111, 16'h2222};
    test_session("single_word", 16'h0100, 1'b0);
    hw_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    test_session("odd_tail", 16'h0100, 1'b0);
    hw_q = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
    test_session("addr_wrap", 16'hFFFC, 1'b0);
    hw_q = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    test_session("ignored_inputs", 16'h0200, 1'b1);
  endtask

  task automatic test_mid_write_reset();
    bit ok;
    int waited;
    int d0;
    hw_q = '{16'($urandom), 16'($urandom)};
    @(negedge clk);
    start_write   = 1'b1;
    start_address = 16'h0300;
    @(negedge clk);
    start_write = 1'b0;
    feed(1'b0, ok);
    #1;
    waited = 0;
    while (write !== 1'b1 && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (write !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_write_pre: got write=%b expected 1 in second write cycle", write);
    end
    d0  = done_cnt;
    rst = 1'b1;
    #1;
    n_vec++;
    if (write !== 1'b0 || busy !== 1'b0 || data_ready !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_write_strobes: got w=%b busy=%b rdy=%b done=%b expected 0000",
               write, busy, data_ready, done);
    end
    n_vec++;
    if (address !== '0 || write_data !== '0) begin
      n_err++;
      $display("FAIL rst_mid_write_regs: got addr=%h data=%h expected 0 0", address, write_data);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_vec++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_write_after: got done_pulses=%0d busy=%b expected 0 0",
               done_cnt - d0, busy);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [AW-1:0] sa;
    int n;
    for (int s = 0; s < 8; s++) begin
      r  = $urandom;
      sa = (s % 3 == 0) ? AW'(16'hFFF0 | {r[3:2], 2'b00}) : {r[AW-1:2], 2'b00};
      n  = $urandom_range(1, 7);
      hw_q.delete();
      for (int i = 0; i < n; i++) hw_q.push_back(16'($urandom));
      test_session("random", sa, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst           = 1'b1;
    start_write   = 1'b0;
    start_address = '0;
    data_in       = '0;
    data_valid    = 1'b0;
    data_last     = 1'b0;
    #2;
    test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_mid_write_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_write.md
SRAM_WRITE -- requirements
Module: sram_write

Interface
REQ-001 Parameter: ADDR_W, 16, SRAM byte-address width.
REQ-002 Parameter: WAIT_CYCLES, 3, cycles each SRAM write strobe is held (>=1).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start_write  input  1  one-cycle pulse; begin result write-back session.
REQ-006 start_address  input  ADDR_W  byte address of first word, sampled with start_write.
REQ-007 data_in  input  16  ANN result halfword.
REQ-008 data_valid  input  1  data_in valid.
REQ-009 data_last  input  1  qualifies data_in as final halfword of session.
REQ-010 data_ready  output  1  block accepts data_in this cycle.
REQ-011 address  output  ADDR_W  SRAM byte address.
REQ-012 write_data  output  32  SRAM write word.
REQ-013 write  output  1  SRAM write strobe.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at session end.

Function
REQ-016 States SHALL be IDLE, COLLECT_LO, COLLECT_HI, WRITE, DONE.
REQ-017 IDLE: start_write=1 latches start_address into address register, clears packing register, next state COLLECT_LO; start_write outside IDLE SHALL be ignored.
REQ-018 data_ready SHALL be 1 only in COLLECT_LO and COLLECT_HI; a transfer occurs on data_valid&&data_ready.
REQ-019 COLLECT_LO transfer: data_in -> write_data[15:0], write_data[31:16] cleared; next COLLECT_HI, or WRITE with last flag set if data_last=1 (upper half stays 0x0000).
REQ-020 COLLECT_HI transfer: data_in -> write_data[31:16]; next WRITE; last flag = data_last.
REQ-021 WRITE: write=1 with address and write_data stable for exactly WAIT_CYCLES consecutive cycles, timed by sub-counter.
REQ-022 End of WRITE: last flag set -> DONE; else address += 4 (modulo 2^ADDR_W, wraps to 0) and -> COLLECT_LO.
REQ-023 DONE: done=1 for one cycle, last flag cleared, -> IDLE; address retains final word address.
REQ-024 write SHALL be 0 in all states except WRITE; no transfer accepted during WRITE or DONE.
REQ-025 data_last with data_valid=0 SHALL have no effect.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, address=0, write_data=0, write=0, data_ready=0, busy=0, done=0, counter=0, last flag=0.
REQ-027 Reset mid-session SHALL abandon the session with no done pulse; a write in progress is truncated asynchronously.

Configuration
REQ-028 Macro SRAM_WRITE_CNT_EN defined: extra output words_written (ADDR_W) cleared on start_write, incremented at each completed WRITE, reset to 0, held after DONE.
REQ-029 Macro undefined: port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package ann_sram_pkg SHALL hold the state enum typedef, default ADDR_W, default WAIT_CYCLES, and the address increment constant (4).
REQ-031 One sub-module sram_write_timer SHALL count WAIT_CYCLES (inputs clk, rst, start; output expired).

Verification
REQ-032 start_address=0x0100, halfwords 0x1111, 0x2222(last) -> one write @0x0100 data 0x22221111 held 3 cycles, then done pulse, busy low.
REQ-033 0xAAAA, 0xBBBB, 0xCCCC(last) from 0x0100 -> 0xBBBBAAAA @0x0100, 0x0000CCCC @0x0104, one done.
REQ-034 start_address=0xFFFC, four halfwords -> writes @0xFFFC then @0x0000.
REQ-035 rst asserted during 2nd WRITE cycle -> write=0 same cycle, state IDLE, no done.
REQ-036 start_write during COLLECT_HI and data_valid during WRITE -> both ignored, data_ready=0 in WRITE, sequence unchanged.
REQ-037 With SRAM_WRITE_CNT_EN, scenario REQ-033 -> words_written=2 after done.
